// File: rtl/interrupt_controller.sv
// Interrupt controller for the 68030 CPU.
// Level requests from the peripherals are turned into pending bits on their rising edges.
// A CPU-writable mask selects which pending bits take part. The highest active level is
// presented to the CPU on ipl_n, and the interrupt-acknowledge bus cycle is answered with
// a vector and a one-cycle iack_ack strobe.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-low reset
//   irq_in      level requests; source i maps to IPL level i+1
//   write       register write strobe, qualified by the chip selects
//   mask_cs     selects the mask register (takes precedence over pending_cs)
//   pending_cs  selects the pending register (write-1-to-clear)
//   data_in     write data; byte lane [31:24], bit 24+i maps to source i
//   data_out    {1'b0, pending, 1'b0, mask, 16'h0}, independent of chip select
//   ipl_n       registered, active-low encoded priority level
//   iack        CPU interrupt-acknowledge cycle active
//   iack_level  level being acknowledged (A3:A1)
//   iack_ack    one-cycle strobe, vector valid in the same cycle
//   vector      interrupt vector number, held until the next acknowledge capture
module interrupt_controller #(
  parameter int unsigned NUM_SOURCES     = 7,
  parameter logic [7:0]  VECTOR_BASE     = 8'h40,
  parameter logic [7:0]  SPURIOUS_VECTOR = 8'h18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic                   write,
  input  logic                   mask_cs,
  input  logic                   pending_cs,
  input  logic [31:0]            data_in,
  output logic [31:0]            data_out,
  output logic [2:0]             ipl_n,
  input  logic                   iack,
  input  logic [2:0]             iack_level,
  output logic                   iack_ack,
  output logic [7:0]             vector
);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] irq_prev_q;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic [2:0]             ipl_n_q, ipl_n_d;
  logic [7:0]             vector_q, vector_d;
  logic [NUM_SOURCES-1:0] irq_rise;
  logic [NUM_SOURCES-1:0] active;
  logic [NUM_SOURCES-1:0] clear;

  // Only the top byte lane carries register data.
  logic unused_data;
  assign unused_data = ^{data_in[31:24+NUM_SOURCES], data_in[23:0]};

  always_comb begin
    irq_rise = irq_in & ~irq_prev_q;
    active   = pending_q & mask_q;

    // Ascending scan: the last match is the highest level.
    ipl_n_d = 3'b111;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (active[i]) ipl_n_d = ~3'(i + 1);
    end

    mask_d = mask_q;
    clear  = '0;
    if (write && mask_cs) begin
      mask_d = data_in[24 +: NUM_SOURCES];
    end else if (write && pending_cs) begin
      clear = data_in[24 +: NUM_SOURCES];
    end

    state_d  = state_q;
    vector_d = vector_q;
    unique case (state_q)
      StIdle: begin
        if (iack) begin
          state_d  = StAck;
          vector_d = SPURIOUS_VECTOR;
          // Level 0 never matches, so it falls through as spurious.
          for (int i = 0; i < NUM_SOURCES; i++) begin
            if ((iack_level == 3'(i + 1)) && pending_q[i]) begin
              vector_d = VECTOR_BASE + 8'(iack_level);
              clear[i] = 1'b1;
            end
          end
        end
      end
      StAck:   state_d = StWait;
      StWait:  if (!iack) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A fresh edge wins over any clear of the same bit.
    pending_d = (pending_q & ~clear) | irq_rise;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      ipl_n_q    <= 3'b111;
      vector_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      ipl_n_q    <= ipl_n_d;
      vector_q   <= vector_d;
    end
  end

  always_comb begin
    data_out                       = '0;
    data_out[24 +: NUM_SOURCES]    = pending_q;
    data_out[16 +: NUM_SOURCES]    = mask_q;
  end

  assign ipl_n    = ipl_n_q;
  assign vector   = vector_q;
  assign iack_ack = (state_q == StAck);

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits downstream of the timer and other peripherals and consumes their level irq outputs.
- Latches rising edges into a pending register, applies a CPU-writable mask and presents the highest-priority request to the 68030 as encoded ipl_n.
- Services the CPU interrupt-acknowledge cycle with a vector and a one-cycle ack strobe.
- Uses the same chip-select/write register convention as the other MAXI030 peripherals; 8-bit data travels on data_in[31:24].

Parameters:
- NUM_SOURCES, 7, number of irq inputs; source i is hard-wired to IPL level i+1, so source 6 is level 7 (NMI).
- VECTOR_BASE, 8'h40, vector returned for level L is VECTOR_BASE + L.
- SPURIOUS_VECTOR, 8'h18, vector returned when the acknowledged level has nothing pending.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- irq_in  input  NUM_SOURCES  level requests from peripherals (timer irq on bit 4 at top level)
- write  input  1  register write strobe, qualified by the chip selects
- mask_cs  input  1  selects mask register
- pending_cs  input  1  selects pending register
- data_in  input  32  write data; bits [24+i] map to source i
- data_out  output  32  read data: {1'b0, pending[6:0], 1'b0, mask[6:0], 16'h0}, independent of chip select
- ipl_n  output  3  active-low encoded priority level to CPU
- iack  input  1  CPU interrupt-acknowledge cycle active (held for the whole bus cycle)
- iack_level  input  3  level being acknowledged (A3:A1 during IACK)
- iack_ack  output  1  one-cycle strobe; vector is valid in the same cycle
- vector  output  8  interrupt vector number

Behaviour:
- Reset (reset==0 at a clock edge):
  - pending=0, mask=0 (all masked), irq_prev=0, ipl_n=3'b111.
  - iack_ack=0, vector=8'h00, FSM=IDLE.
  - Applies mid-IACK too: the FSM aborts to IDLE and no ack is issued.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - pending[i] is set on any cycle with irq_in[i] & ~irq_prev[i].
  - A level held high raises pending once only; it must fall and rise again to re-raise.
  - Edges on masked sources still set pending.
- Register writes:
  - write & mask_cs: mask <= data_in[30:24].
  - write & pending_cs: write-1-to-clear; pending[i] is cleared where data_in[24+i]==1.
  - If both chip selects are asserted, mask_cs wins; no pending clear occurs.
- Priority:
  - active = pending & mask.
  - ipl_n is registered (1-cycle latency) as ~(index of highest set bit of active + 1), or 3'b111 if active==0.
  - Source 6 (level 7) is subject to the mask like every other source.
- IACK FSM:
  - IDLE -> ACK when iack==1. In this transition:
    - L = iack_level.
    - If L in 1..7 and pending[L-1]: vector <= VECTOR_BASE+L and pending[L-1] is cleared.
    - Otherwise vector <= SPURIOUS_VECTOR.
  - ACK: iack_ack=1 for exactly this one cycle, vector valid; unconditionally -> WAIT.
  - WAIT: iack_ack=0; -> IDLE when iack==0. No second ack is issued within one iack assertion.
  - Latency: iack high on edge N gives iack_ack high during cycle N+1.
  - vector holds its value until the next IACK capture.
- Simultaneous events on the same bit in one cycle:
  - A new rising edge beats any clear (W1C write or IACK clear); pending stays 1.
  - A W1C write and an IACK clear of different bits are both applied.
- Width rules:
  - VECTOR_BASE+L is 8-bit and wraps modulo 256; no saturation.
  - iack_level==0 is treated as spurious.

Test Plan:
- Reset, write mask=8'h7F on data_in[31:24], pulse irq_in[4] 0->1 and hold -> pending=7'h10, ipl_n=3'b010 one cycle after pending sets; hold irq_in[4] high 20 cycles -> no re-trigger after W1C clear.
- irq_in[1] and irq_in[5] rise together, mask=7'h7F -> ipl_n=3'b001 (level 6); IACK with level 6 -> vector=8'h46, iack_ack one cycle, pending=7'h02, ipl_n then 3'b101.
- mask=7'h00 with an edge on source 3 -> pending[3]=1, ipl_n=3'b111; write mask=7'h08 -> ipl_n=3'b011 one cycle later.
- IACK level 3 with pending=0 -> vector=8'h18, iack_ack one cycle; iack held 5 cycles -> iack_ack never reasserts.
- W1C write to bit 2 in the same cycle as a rising irq_in[2] -> pending[2] stays 1.
- Assert reset (low) in cycle N+1 of an IACK -> iack_ack=0, ipl_n=3'b111, pending=0, mask=0, FSM=IDLE.
